// File: rtl/apb_reg_completer.sv
// ---------------------------------------------------------------------------
// apb_reg_completer
//
// APB4 completer that terminates transfers into a bank of 32-bit software
// registers. Accesses are word aligned, writes honour byte strobes, every
// transfer carries a fixed number of wait states, and illegal accesses are
// answered with PSLVERR. The last register is a read-only view of hw_status.
//
// Parameters
//   ADDR_WIDTH  : PADDR width; any address at or above 4*NUM_REGS is illegal
//   NUM_REGS    : number of registers (2..16); index NUM_REGS-1 is status
//   WAIT_STATES : wait cycles inserted per transfer (0..15)
//
// Ports
//   PCLK, PRESETn        : clock, synchronous active-low reset
//   PSEL, PENABLE        : APB select / access-phase indicator
//   PWRITE, PADDR        : direction and byte address (captured at setup)
//   PWDATA, PSTRB        : write data and byte lanes (sampled at completion)
//   PPROT                : protection; bit 0 = privileged
//   hw_status            : value returned by reads of the status register
//   PRDATA, PREADY,
//   PSLVERR              : completion response, driven only from state
//   regs_flat            : current register contents, reg i at [32i+31:32i]
// ---------------------------------------------------------------------------
module apb_reg_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDR_WIDTH-1:0]    PADDR,
    input  logic [31:0]              PWDATA,
    input  logic [3:0]               PSTRB,
    input  logic [2:0]               PPROT,
    input  logic [31:0]              hw_status,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [32*NUM_REGS-1:0]   regs_flat
);

    localparam logic [3:0]            STATUS_IDX = 4'(NUM_REGS - 1);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * NUM_REGS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [3:0]  regIdx_q, regIdx_d;
    logic        isWrite_q, isWrite_d;
    logic        isErr_q, isErr_d;

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic [3:0]  setupIdx;
    logic        setupErr;
    logic        doWrite;
    logic [31:0] readMux;
    logic        unusedProt;

    // Only the privileged bit of PPROT matters to this completer.
    assign unusedProt = ^PPROT[2:1];

    // Decode of the setup-phase address. The full-width compare against
    // 4*NUM_REGS also rejects any address with a nonzero upper bit.
    always_comb begin
        setupIdx = PADDR[5:2];
        setupErr = 1'b0;
        if (PADDR[1:0] != 2'b00) begin
            setupErr = 1'b1;
        end
        if (PADDR >= ADDR_LIMIT) begin
            setupErr = 1'b1;
        end
        if (PWRITE && (setupIdx == STATUS_IDX)) begin
            setupErr = 1'b1;
        end
        if ((setupIdx == 4'd0) && !PPROT[0]) begin
            setupErr = 1'b1;
        end
    end

    // Next-state logic. A dropped PSEL during ACCESS abandons the transfer
    // silently; PSEL+PENABLE seen in IDLE is not a setup and is ignored.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        regIdx_d  = regIdx_q;
        isWrite_d = isWrite_q;
        isErr_d   = isErr_q;
        doWrite   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d   = ACCESS;
                    waitCnt_d = WAIT_LOAD;
                    regIdx_d  = setupIdx;
                    isWrite_d = PWRITE;
                    isErr_d   = setupErr;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    waitCnt_d = 4'd0;
                end else if (waitCnt_q != 4'd0) begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    doWrite = isWrite_q && !isErr_q;
                end
            end
            default: begin
                state_d   = IDLE;
                waitCnt_d = 4'd0;
            end
        endcase
    end

    // Register bank update. The status slot is never written (a write to it
    // is always flagged as an error), so it stays at its reset value.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS - 1; r++) begin
            if (doWrite && (regIdx_q == 4'(r))) begin
                for (int b = 0; b < 4; b++) begin
                    if (PSTRB[b]) begin
                        regs_d[r][8*b +: 8] = PWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            regIdx_q  <= 4'd0;
            isWrite_q <= 1'b0;
            isErr_q   <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            regIdx_q  <= regIdx_d;
            isWrite_q <= isWrite_d;
            isErr_q   <= isErr_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read mux over the captured index; the status slot returns the live
    // hw_status input instead of stored contents.
    always_comb begin
        readMux = 32'd0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (regIdx_q == 4'(r)) begin
                readMux = regs_q[r];
            end
        end
        if (regIdx_q == STATUS_IDX) begin
            readMux = hw_status;
        end
    end

    // Response outputs depend only on registered state, never on PSEL or
    // PENABLE directly.
    always_comb begin
        PREADY  = (state_q == ACCESS) && (waitCnt_q == 4'd0);
        PSLVERR = PREADY && isErr_q;
        PRDATA  = 32'd0;
        if (PREADY && !isWrite_q && !isErr_q) begin
            PRDATA = readMux;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_flat[32*r +: 32] = regs_q[r];
        end
    end

endmodule
